uart_fifo: RTL

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: UART transceiver with 16x oversampling and show-ahead TX/RX FIFOs.
module uart_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            wdata,
    output logic [W-1:0]            rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr, rd;
    assign full  = count == FULL_CNT;
    assign empty = count == '0;
    assign rd    = pop && !empty;
    // a push into a full buffer still lands when the head leaves in the same cycle
    assign wr    = push && (!full || rd);
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wdata;
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(rd);
            count  <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

module uart_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          tx,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count
);
    localparam int DIV = CLOCK_FREQ / (BAUD_RATE * 16);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DW-1:0] div_cnt;
    logic tick;
    assign tick = div_cnt == DW'(DIV - 1);
    always_ff @(posedge clk)
        if (rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + 1'b1;

    state_t tx_st, tx_nx;
    logic [3:0] tx_tck;
    logic [2:0] tx_idx;
    logic [DATA_BITS-1:0] tx_sh, tx_head;
    logic tx_par, tx_pop, tx_bit_end, tx_full, tx_empty;
    assign tx_bit_end = tick && tx_tck == 4'd15;

    uart_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
        .clk(clk), .rst(rst), .push(tx_valid && !tx_full), .pop(tx_pop),
        .wdata(tx_data), .rdata(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    always_comb begin
        tx_nx  = tx_st;
        tx_pop = 1'b0;
        case (tx_st)
            S_IDLE:   if (tick && !tx_empty) begin tx_pop = 1'b1; tx_nx = S_START; end
            S_START:  if (tx_bit_end) tx_nx = S_DATA;
            S_DATA:   if (tx_bit_end && tx_idx == 3'(DATA_BITS - 1)) tx_nx = PARITY != 0 ? S_PARITY : S_STOP;
            S_PARITY: if (tx_bit_end) tx_nx = S_STOP;
            S_STOP:   if (tx_bit_end && tx_idx == 3'(STOP_BITS - 1)) begin
                // chain straight into the next frame so there is no idle gap
                tx_pop = !tx_empty;
                tx_nx  = tx_empty ? S_IDLE : S_START;
            end
            default:  tx_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st  <= S_IDLE;
            tx_tck <= '0;
            tx_idx <= '0;
            tx_sh  <= '0;
            tx_par <= 1'b0;
        end else begin
            tx_st  <= tx_nx;
            tx_tck <= tx_st == S_IDLE ? '0 : tx_tck + 4'(tick);
            tx_idx <= tx_nx != tx_st ? '0 : tx_idx + 3'(tx_bit_end);
            if (tx_pop) begin
                tx_sh  <= tx_head;
                tx_par <= PARITY == 1 ? ~^tx_head : ^tx_head;
            end else if (tx_st == S_DATA && tx_bit_end) tx_sh <= tx_sh >> 1;
        end
    end

    assign tx = tx_st == S_START ? 1'b0 : tx_st == S_DATA ? tx_sh[0] : tx_st == S_PARITY ? tx_par : 1'b1;
    assign tx_ready = !tx_full;
    assign tx_busy  = tx_st != S_IDLE || !tx_empty;

    logic rx_s1, rx_s2;
    state_t rx_st, rx_nx;
    logic [3:0] rx_tck;
    logic [2:0] rx_idx;
    logic [DATA_BITS-1:0] rx_sh;
    logic [DATA_BITS+1:0] rx_head;
    logic rx_perr, rx_smp, rx_store, rx_full, rx_empty;
    // START samples half a bit in; later states sample one full bit after that
    assign rx_smp = tick && rx_tck == (rx_st == S_START ? 4'd7 : 4'd15);

    always_comb begin
        rx_nx    = rx_st;
        rx_store = 1'b0;
        case (rx_st)
            S_IDLE:   if (!rx_s2) rx_nx = S_START;
            S_START:  if (rx_smp) rx_nx = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (rx_smp && rx_idx == 3'(DATA_BITS - 1)) rx_nx = PARITY != 0 ? S_PARITY : S_STOP;
            S_PARITY: if (rx_smp) rx_nx = S_STOP;
            S_STOP:   if (rx_smp) begin rx_store = 1'b1; rx_nx = S_IDLE; end
            default:  rx_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_s2, rx_s1} <= 2'b11;
            rx_st      <= S_IDLE;
            rx_tck     <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rx_perr    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            {rx_s2, rx_s1} <= {rx_s1, rx};
            rx_st  <= rx_nx;
            rx_tck <= (rx_st == S_IDLE || rx_nx != rx_st) ? '0 : rx_tck + 4'(tick);
            rx_idx <= rx_nx != rx_st ? '0 : rx_idx + 3'(rx_smp);
            if (rx_st == S_DATA && rx_smp) rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            rx_perr <= rx_st == S_START ? 1'b0
                     : (rx_st == S_PARITY && rx_smp) ? rx_s2 != (PARITY == 1 ? ~^rx_sh : ^rx_sh)
                     : rx_perr;
            rx_overrun <= rx_store && rx_full && !rx_ready;
        end
    end

    uart_fifo_buf #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rxf (
        .clk(clk), .rst(rst), .push(rx_store), .pop(rx_ready),
        .wdata({rx_sh, rx_perr, ~rx_s2}), .rdata(rx_head), .count(rx_count),
        .full(rx_full), .empty(rx_empty)
    );

    assign rx_valid = !rx_empty;
    assign {rx_data, rx_parity_err, rx_frame_err} = rx_valid ? rx_head : '0;
endmodule
